// File: rtl/ps2_kbd_rx_if.sv
// ps2_kbd_rx_if: keyboard byte/strobe/error bus from the PS/2 receiver to the keyboard FIFO
interface ps2_kbd_rx_if;
  logic [7:0] code_o;
  logic       strobe_o;
  logic       err_o;
  modport master (output code_o, strobe_o, err_o);
  modport slave (input code_o, strobe_o, err_o);
endinterface

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: receive-only PS/2 keyboard frame decoder with parity/stop/timeout checks
// Define PS2_FILTER_EN to build a FILTER_LEN-deep glitch filter on the PS/2 clock.
module ps2_kbd_rx #(
  parameter int FREQ_HZ    = 12000000,
  parameter int TIMEOUT_US = 200,
  parameter int FILTER_LEN = 8
) (
  input logic          clk,
  input logic          reset_i,
  input logic          ps2_clk_i,
  input logic          ps2_data_i,
  ps2_kbd_rx_if.master kbd
);
  localparam int TC = (FREQ_HZ / 1000000) * TIMEOUT_US;
  localparam int TW = $clog2(TC);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  logic [1:0] r_clk_s, r_dat_s;
  logic r_clk_prev, r_fall, r_dat_d;
  logic w_clk_f;
  state_t r_state, w_state;
  logic [2:0] r_bit, w_bit;
  logic [7:0] r_sr, w_sr, r_code, w_code;
  logic r_par, w_par, r_strobe, w_strobe, r_err, w_err;
  logic [TW-1:0] r_to, w_to;
  logic w_tmo, w_valid, w_sat;
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_clk_s    <= 2'b11;
      r_dat_s    <= 2'b11;
      r_clk_prev <= 1'b1;
      r_fall     <= 1'b0;
      r_dat_d    <= 1'b1;
    end else begin
      r_clk_s    <= {r_clk_s[0], ps2_clk_i};
      r_dat_s    <= {r_dat_s[0], ps2_data_i};
      r_clk_prev <= w_clk_f;
      r_fall     <= r_clk_prev & ~w_clk_f;
      r_dat_d    <= r_dat_s[1];
    end
  end
`ifdef PS2_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic r_filt;
  logic [FW-1:0] r_fcnt;
  // Filtered level flips only after FILTER_LEN consecutive samples disagree with it
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_filt <= 1'b1;
      r_fcnt <= '0;
    end else if (r_clk_s[1] == r_filt) begin
      r_fcnt <= '0;
    end else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
      r_filt <= r_clk_s[1];
      r_fcnt <= '0;
    end else begin
      r_fcnt <= r_fcnt + 1'b1;
    end
  end
  assign w_clk_f = r_filt;
`else
  assign w_clk_f = r_clk_s[1];
`endif
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_state  <= IDLE;
      r_bit    <= '0;
      r_sr     <= '0;
      r_par    <= 1'b0;
      r_to     <= '0;
      r_code   <= '0;
      r_strobe <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_bit    <= w_bit;
      r_sr     <= w_sr;
      r_par    <= w_par;
      r_to     <= w_to;
      r_code   <= w_code;
      r_strobe <= w_strobe;
      r_err    <= w_err;
    end
  end
  // A fall on the same cycle as the timeout limit keeps the frame alive
  always_comb begin
    w_sat    = r_to == TW'(TC - 1);
    w_tmo    = (r_state != IDLE) && !r_fall && w_sat;
    w_valid  = r_dat_d && (^{r_sr, r_par});
    w_to     = (r_state == IDLE || r_fall) ? '0 : w_sat ? r_to : r_to + 1'b1;
    w_state  = r_state;
    w_bit    = r_bit;
    w_sr     = r_sr;
    w_par    = r_par;
    w_code   = r_code;
    w_strobe = 1'b0;
    w_err    = 1'b0;
    if (w_tmo) begin
      w_state = IDLE;
      w_err   = 1'b1;
    end else if (r_fall) begin
      case (r_state)
        IDLE: begin
          w_state = r_dat_d ? IDLE : DATA;
          w_bit   = '0;
        end
        DATA: begin
          w_sr    = {r_dat_d, r_sr[7:1]};
          w_bit   = r_bit + 1'b1;
          w_state = (r_bit == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          w_par   = r_dat_d;
          w_state = STOP;
        end
        default: begin
          w_state  = IDLE;
          w_code   = w_valid ? r_sr : r_code;
          w_strobe = w_valid;
          w_err    = !w_valid;
        end
      endcase
    end
  end
  assign kbd.code_o   = r_code;
  assign kbd.strobe_o = r_strobe;
  assign kbd.err_o    = r_err;
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: randomized PS/2 frames checked through an expected-event scoreboard
module tb_ps2_kbd_rx;
  logic clk = 0, reset_i = 1, ps2_clk_i = 1, ps2_data_i = 1;
  ps2_kbd_rx_if bus();
  ps2_kbd_rx dut (.clk(clk), .reset_i(reset_i), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i), .kbd(bus));
  always #5 clk = ~clk;
`ifdef PS2_FILTER_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 0;
`endif
  typedef struct {bit err; logic [7:0] code; int lo; int hi;} exp_t;
  exp_t q[$];
  exp_t e_m;
  int checks = 0, failures = 0, cyc = 0, last_fall = 0;
  logic [7:0] m_code = 8'h00;
  bit prev_ev = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (!reset_i && (bus.strobe_o || bus.err_o)) begin
      chk("exclusive", {31'b0, bus.strobe_o & bus.err_o}, 0);
      chk("one_cycle", {31'b0, prev_ev}, 0);
      if (q.size() == 0) chk("unexpected_event", {31'b0, bus.err_o}, {31'b0, bus.strobe_o});
      else begin
        e_m = q.pop_front();
        chk(e_m.err ? "kind_err" : "kind_strobe", {31'b0, bus.err_o}, {31'b0, e_m.err});
        chk("code", {24'b0, bus.code_o}, {24'b0, e_m.code});
        if (e_m.hi > 0) chk("timeout_window", {31'b0, cyc >= e_m.lo && cyc <= e_m.hi}, 1);
      end
    end
    prev_ev <= !reset_i && (bus.strobe_o || bus.err_o);
  end
  task automatic send(input logic [7:0] d, input bit par, input bit stp, input int h, input int nbits);
    logic [10:0] f;
    f = {stp, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data_i = f[i];
      repeat (h) @(posedge clk);
      ps2_clk_i = 0;
      last_fall = cyc;
      repeat (h) @(posedge clk);
      ps2_clk_i = 1;
    end
    ps2_data_i = 1;
  endtask
  // kind 0 good, 1 parity wrong, 2 stop bit wrong
  task automatic frame(input logic [7:0] d, input int kind, input int h);
    bit par;
    par = ($countones(d) % 2 == 0);
    if (kind == 1) par = ~par;
    if (kind == 0) begin
      q.push_back('{0, d, 0, 0});
      m_code = d;
    end else q.push_back('{1, m_code, 0, 0});
    send(d, par, kind != 2, h, 11);
  endtask
  task automatic drain();
    for (int i = 0; i < 6000 && q.size() > 0; i++) @(posedge clk);
    chk("drain", q.size(), 0);
  endtask
  task automatic expect_timeout(input int t0);
    q.push_back('{1, m_code, t0 + 2398 + LAT, t0 + 2410 + LAT});
  endtask
  initial begin
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_code", {24'b0, bus.code_o}, 0);
    chk("reset_strobe", {31'b0, bus.strobe_o}, 0);
    chk("reset_err", {31'b0, bus.err_o}, 0);
    @(posedge clk);
    reset_i = 0;
    repeat (10) @(posedge clk);
    frame(8'h1C, 0, 240);
    drain();
    frame(8'hF0, 0, 40);
    frame(8'h1C, 0, 40);
    drain();
    frame(8'h1C, 1, 40);
    drain();
    send(8'h05, 0, 1, 40, 5);
    expect_timeout(last_fall);
    repeat (3000) @(posedge clk);
    chk("timeout_seen", q.size(), 0);
    frame(8'h5A, 0, 40);
    drain();
    send(8'h1F, 0, 1, 40, 6);
    @(posedge clk);
    reset_i = 1;
    @(posedge clk);
    reset_i = 0;
    m_code = 8'h00;
    @(negedge clk);
    chk("midreset_code", {24'b0, bus.code_o}, 0);
    chk("midreset_strobe", {31'b0, bus.strobe_o}, 0);
    chk("midreset_err", {31'b0, bus.err_o}, 0);
    repeat (3000) @(posedge clk);
    frame(8'h1C, 0, 40);
    drain();
    @(posedge clk);
    ps2_data_i = 0;
    ps2_clk_i = 0;
`ifndef PS2_FILTER_EN
    expect_timeout(cyc);
`endif
    repeat (3) @(posedge clk);
    ps2_clk_i = 1;
    repeat (6) @(posedge clk);
    ps2_data_i = 1;
    repeat (3000) @(posedge clk);
    chk("glitch_result", q.size(), 0);
    for (int n = 0; n < 24; n++) begin
      int r;
      r = $urandom_range(0, 9);
      frame(8'($urandom), r < 7 ? 0 : (r < 9 ? 1 : 2), $urandom_range(12, 60));
      repeat ($urandom_range(0, 20)) @(posedge clk);
    end
    drain();
    @(negedge clk);
    chk("final_code", {24'b0, bus.code_o}, {24'b0, m_code});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ps2_kbd_rx.md
# ps2_kbd_rx

Receives PS/2 keyboard frames on the raw PS/2 clock/data pins and delivers one byte per valid frame as a single-cycle strobe. It sits directly upstream of the SoC's PS/2 keyboard FIFO and drives its `ps2_kbd_code_i`, `ps2_kbd_strobe_i` and `ps2_kbd_err_i` inputs. It is receive-only; the host never drives the PS/2 lines.

## Interface
- `FREQ_HZ`, default 12000000: system clock frequency in Hz.
- `TIMEOUT_US`, default 200: maximum gap between PS/2 clock falling edges inside a frame. `TIMEOUT_CYCLES = (FREQ_HZ/1000000)*TIMEOUT_US`, which is 2400 at the defaults.
- `FILTER_LEN`, default 8: glitch filter depth in clock cycles. Used only when `PS2_FILTER_EN` is defined.
- `clk`, input, 1: system clock. Single clock domain.
- `reset_i`, input, 1: synchronous, active-high reset.
- `ps2_clk_i`, input, 1: raw PS/2 clock pin. Asynchronous.
- `ps2_data_i`, input, 1: raw PS/2 data pin. Asynchronous.
- `code_o`, output, 8: last correctly received byte.
- `strobe_o`, output, 1: one-cycle pulse when `code_o` has just been updated.
- `err_o`, output, 1: one-cycle pulse on parity error, stop-bit error or timeout.

## Operation
- **Synchronisers:** both pins pass through 2-flop synchronisers, each reset to 1.
- **Falling edge:** defined as previous filtered clock = 1 and current = 0. A one-cycle internal `fall` pulse is registered on it.
- **Data sampling:** the synchronised `ps2_data_i` is sampled only on `fall`.
- **Frame format:** 11 bits: start (0), 8 data bits LSB first, odd parity, stop (1).
- **FSM states:** IDLE, DATA, PARITY, STOP.
- **IDLE:**
  - On `fall` with data = 0: go to DATA, clear bit counter and timeout counter.
  - On `fall` with data = 1: treated as a glitch. Stay in IDLE, no `err_o`.
- **DATA:**
  - On each `fall`, shift data into bit 7 of an 8-bit shift register (right shift) and increment the 3-bit counter.
  - After the 8th bit (counter wraps 7→0), go to PARITY.
- **PARITY:** on `fall`, store the parity bit and go to STOP.
- **STOP:** on `fall`, go to IDLE and classify the frame:
  - Valid = stop bit = 1 AND XOR of the 8 data bits and parity = 1.
  - Valid: load `code_o` with the shift register and pulse `strobe_o`.
  - Invalid: pulse `err_o`; `code_o` is unchanged.
- **Timeout:**
  - In any state other than IDLE, a counter increments every cycle and clears on `fall`.
  - When it reaches `TIMEOUT_CYCLES-1`, the frame is aborted: return to IDLE and pulse `err_o`.
  - The counter saturates and never wraps.
- **Simultaneous `fall` and timeout on the same cycle:** `fall` wins; the counter clears and the frame continues.
- `strobe_o` and `err_o` are never high on the same cycle.
- **Reset:**
  - Applies on any cycle, including mid-frame.
  - FSM goes to IDLE; counters and shift register clear.
  - Outputs: `code_o` = 0x00, `strobe_o` = 0, `err_o` = 0.
  - A frame in progress at reset is dropped, with no strobe and no error.

## Timing
- **Pin edge to `fall`:** 3 cycles (2 sync + 1 edge register). With the filter enabled, add `FILTER_LEN` cycles.
- **Stop-bit `fall` to output:** `strobe_o`/`err_o` is high on the cycle after the `fall` pulse, for exactly 1 cycle.
- **`code_o` update:** takes its new value on the same cycle `strobe_o` rises, and holds until the next valid frame.
- **Timeout `err_o`:** high on the cycle after the counter reaches `TIMEOUT_CYCLES-1`.
- **Back-to-back frames:** supported with no dead cycles. A start-bit `fall` in the cycle directly after STOP is accepted.

## Configuration
- **`PS2_FILTER_EN` defined:**
  - The filtered clock changes only after `FILTER_LEN` consecutive identical synchronised samples.
  - Pulses shorter than `FILTER_LEN` cycles are ignored.
  - Filter state resets to 1.
- **`PS2_FILTER_EN` undefined:** the filtered clock equals the 2-flop synchronised clock. No filter logic is built and no extra latency is added.

## Test plan
- **Valid 0x1C:** start 0, data 0x1C LSB first, parity 0, stop 1, 40 µs bit period → one `strobe_o` pulse, `code_o` = 0x1C, `err_o` never high.
- **Back-to-back 0xF0 then 0x1C:** 0xF0 sent with parity 1, then 0x1C → two strobes, `code_o` = 0xF0 then 0x1C.
- **Parity error:** `code_o` holds 0x1C; send 0x1C with parity 1 → one `err_o` pulse, no strobe, `code_o` stays 0x1C.
- **Timeout and recovery:** send start plus 4 data bits, hold PS/2 clock high for 3000 cycles → `err_o` pulses once at cycle 2400 after the last `fall`. Then send 0x5A with parity 1 → strobe, `code_o` = 0x5A.
- **Reset mid-frame:** assert `reset_i` for 1 cycle after 5 data bits → no strobe and no err. Outputs are 0x00/0/0, and the next 0x1C frame is received correctly.
- **Glitch filter (with `PS2_FILTER_EN`):**
  - 3-cycle low pulse on PS/2 clock while idle → ignored, FSM stays IDLE.
  - Without the macro, the same pulse is seen as a start-bit `fall` when data = 0; the frame then times out with one `err_o`.
